// File: rtl/mining_pkg.sv
// Shared mining-domain types: job field widths, dispatcher states and the leading-zero hit mask.
package mining_pkg;

  localparam int unsigned MIDSTATE_W = 256;
  localparam int unsigned DATA_W     = 96;
  localparam int unsigned NONCE_W    = 32;
  localparam int unsigned HASH_W     = 256;
  localparam int unsigned JOB_SIZE   = MIDSTATE_W + DATA_W + 2 * NONCE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } disp_state_t;

  // Job fields held for the whole range; nonce_min only seeds the counter.
  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
    logic [NONCE_W-1:0]    nonce_max;
  } job_latch_t;

  // Ones in the top 'zeros' bits: those bits of the hash must all be clear.
  function automatic logic [HASH_W-1:0] zero_mask(input logic [7:0] zeros);
    zero_mask = ~({HASH_W{1'b1}} >> zeros);
  endfunction

endpackage

// File: rtl/hit_throttle.sv
// Rate-limits golden-nonce reports so the slow-side edge synchroniser sees every toggle.
// NONCE_DISP_STATS_EN adds a registered drop_hit strobe.
module hit_throttle
  import mining_pkg::*;
#(
  parameter int unsigned HIT_GAP = 16
) (
  input  logic               hash_clk,
  input  logic               rst_n,
  input  logic               hit,
  input  logic [NONCE_W-1:0] hit_nonce,
  output logic [NONCE_W-1:0] golden_nonce,
  output logic               new_golden_nonce
`ifdef NONCE_DISP_STATS_EN
  ,
  output logic               drop_hit
`endif
);

  localparam int unsigned        GAP_W    = $clog2(HIT_GAP);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(HIT_GAP - 1);

  logic [GAP_W-1:0]   gap_cnt;
  logic               pend_v;
  logic [NONCE_W-1:0] pend_nonce;

  logic gap_idle_c;
  logic report_pend_c;
  logic report_hit_c;
  logic store_hit_c;

  // A waiting hit always goes first; a new hit only bypasses an empty slot.
  assign gap_idle_c    = (gap_cnt == '0);
  assign report_pend_c = gap_idle_c & pend_v;
  assign report_hit_c  = hit & gap_idle_c & ~pend_v;
  assign store_hit_c   = hit & ~report_hit_c & ~pend_v;

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt          <= '0;
      pend_v           <= 1'b0;
      pend_nonce       <= '0;
      golden_nonce     <= '0;
      new_golden_nonce <= 1'b0;
    end else begin
      if (report_pend_c) begin
        golden_nonce     <= pend_nonce;
        new_golden_nonce <= ~new_golden_nonce;
        gap_cnt          <= GAP_LOAD;
        pend_v           <= 1'b0;
      end else if (report_hit_c) begin
        golden_nonce     <= hit_nonce;
        new_golden_nonce <= ~new_golden_nonce;
        gap_cnt          <= GAP_LOAD;
      end else if (!gap_idle_c) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      if (store_hit_c) begin
        pend_v     <= 1'b1;
        pend_nonce <= hit_nonce;
      end
    end
  end

`ifdef NONCE_DISP_STATS_EN
  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) drop_hit <= 1'b0;
    else        drop_hit <= hit & pend_v;
  end
`endif

endmodule

// File: rtl/nonce_dispatcher.sv
// Issues a latched job's nonce range into the SHA256d core and reports results that meet the target.
// NONCE_DISP_STATS_EN adds hash_count and dropped_hits outputs.
module nonce_dispatcher
  import mining_pkg::*;
#(
  parameter int unsigned HIT_GAP = 16,
  parameter int unsigned OUTST_W = 8
) (
  input  logic                  hash_clk,
  input  logic                  rst_n,
  input  logic                  new_work,
  input  logic [MIDSTATE_W-1:0] midstate,
  input  logic [DATA_W-1:0]     work_data,
  input  logic [NONCE_W-1:0]    nonce_min,
  input  logic [NONCE_W-1:0]    nonce_max,
  input  logic [7:0]            target_zeros,
  output logic                  core_valid,
  input  logic                  core_ready,
  output logic [NONCE_W-1:0]    core_nonce,
  output logic                  core_tag,
  output logic [MIDSTATE_W-1:0] core_midstate,
  output logic [DATA_W-1:0]     core_data,
  input  logic                  res_valid,
  input  logic [NONCE_W-1:0]    res_nonce,
  input  logic                  res_tag,
  input  logic [HASH_W-1:0]     res_hash,
  output logic [NONCE_W-1:0]    golden_nonce,
  output logic                  new_golden_nonce,
  output logic                  busy,
  output logic                  job_done
`ifdef NONCE_DISP_STATS_EN
  ,
  output logic [31:0]           hash_count,
  output logic [7:0]            dropped_hits
`endif
);

  disp_state_t        state;
  job_latch_t         job_q;
  logic [7:0]         zeros_q;
  logic               epoch;
  logic [OUTST_W-1:0] outstanding;
  logic               hit_q;
  logic [NONCE_W-1:0] hit_nonce_q;

  logic xfer_c;
  logic res_cur_c;

  assign xfer_c        = core_valid & core_ready;
  assign res_cur_c     = res_valid & (res_tag == epoch);
  assign core_tag      = epoch;
  assign core_midstate = job_q.midstate;
  assign core_data     = job_q.data;

  // Job control: a new job preempts anything in flight by flipping the epoch.
  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      job_q       <= '0;
      zeros_q     <= '0;
      epoch       <= 1'b0;
      outstanding <= '0;
      core_nonce  <= '0;
      core_valid  <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
    end else begin
      job_done <= 1'b0;
      if (new_work) begin
        job_q.midstate  <= midstate;
        job_q.data      <= work_data;
        job_q.nonce_max <= nonce_max;
        zeros_q         <= target_zeros;
        epoch           <= ~epoch;
        outstanding     <= '0;
        core_nonce      <= nonce_min;
        busy            <= 1'b1;
        if (nonce_min > nonce_max) begin
          state      <= DRAIN;
          core_valid <= 1'b0;
        end else begin
          state      <= RUN;
          core_valid <= 1'b1;
        end
      end else begin
        outstanding <= outstanding + OUTST_W'(xfer_c) - OUTST_W'(res_cur_c);
        case (state)
          RUN: begin
            // Equality stop keeps a range ending at all-ones from wrapping.
            if (xfer_c) begin
              if (core_nonce == job_q.nonce_max) begin
                state      <= DRAIN;
                core_valid <= 1'b0;
              end else begin
                core_nonce <= core_nonce + NONCE_W'(1);
              end
            end
          end
          DRAIN: begin
            if (outstanding == '0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              job_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered target check on current-epoch results.
  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      hit_nonce_q <= '0;
    end else begin
      hit_q       <= res_cur_c & ((res_hash & zero_mask(zeros_q)) == '0);
      hit_nonce_q <= res_nonce;
    end
  end

`ifdef NONCE_DISP_STATS_EN
  logic drop_hit;
`endif

  hit_throttle #(
    .HIT_GAP (HIT_GAP)
  ) u_hit_throttle (
    .hash_clk         (hash_clk),
    .rst_n            (rst_n),
    .hit              (hit_q),
    .hit_nonce        (hit_nonce_q),
    .golden_nonce     (golden_nonce),
    .new_golden_nonce (new_golden_nonce)
`ifdef NONCE_DISP_STATS_EN
    ,
    .drop_hit         (drop_hit)
`endif
  );

`ifdef NONCE_DISP_STATS_EN
  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_count   <= '0;
      dropped_hits <= '0;
    end else begin
      if (new_work)                              hash_count <= '0;
      else if (res_cur_c && hash_count != '1)    hash_count <= hash_count + 32'd1;
      if (drop_hit && dropped_hits != '1)        dropped_hits <= dropped_hits + 8'd1;
    end
  end
`endif

endmodule
